// File: rtl/burst_pkg.sv
// Shared definitions for the burst scheduler: FSM state encoding, default widths
// and a constant-evaluable clog2 helper.
package burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEF_SIZEBURST = 5;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/burst_beat_cnt.sv
// Beat counter for one burst: counts accepted beats, saturates at the latched length
// and flags the beat that completes the burst.
module burst_beat_cnt
    import burst_pkg::*;
#(
    parameter int SIZEBURST = DEF_SIZEBURST
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 go,
    input  logic [SIZEBURST-1:0] len,
    output logic [SIZEBURST-1:0] count,
    output logic                 last
);

    logic [SIZEBURST-1:0] count_q;
    logic [SIZEBURST-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (go && (count_q != len)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = go && (count_q == (len - 1'b1));

endmodule

// File: rtl/burst_scheduler.sv
// Round-robin owner of the shared burst datapath: grants one requester per burst,
// sequences its beats and releases on the last beat or on a stall watchdog.
module burst_scheduler
    import burst_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int SIZEBURST = DEF_SIZEBURST,
    parameter int IDW       = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*SIZEBURST-1:0] req_size,
    input  logic                      beat_valid,
    input  logic                      beat_ready,
    output logic [NREQ-1:0]           gnt,
    output logic [IDW-1:0]            gnt_id,
    output logic                      beat_en,
    output logic                      busy,
    output logic                      burst_done,
    output logic                      burst_abort,
    output logic [1:0]                dbg_state,
    output logic [SIZEBURST-1:0]      dbg_beats
);

    // Handshake: a beat moves only in BURST, in a cycle where beat_valid and
    // beat_ready are both high; beat_en is that combinational AND.

    localparam int SW = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;

    state_e               state_q, state_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic [IDW-1:0]       gnt_id_q, gnt_id_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [SIZEBURST-1:0] len_q, len_d;
    logic [SW-1:0]        stall_q, stall_d;
    logic                 abort_q, abort_d;

    logic [NREQ-1:0]      req_rot;
    logic [IDW-1:0]       off;
    logic [IDW:0]         win_sum;
    logic [IDW-1:0]       winner;
    logic [SIZEBURST-1:0] len_win;
    logic [SIZEBURST-1:0] beat_cnt;
    logic                 beat_last;
    logic                 timeout_hit;

    // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_rot = NREQ'({req, req} >> ptr_q);
        off     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = IDW'(i);
            end
        end
        win_sum = {1'b0, ptr_q} + {1'b0, off};
        if (win_sum >= (IDW+1)'(NREQ)) begin
            win_sum = win_sum - (IDW+1)'(NREQ);
        end
        winner = win_sum[IDW-1:0];
    end

    always_comb begin
        len_win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                len_win = req_size[i*SIZEBURST +: SIZEBURST];
            end
        end
    end

    burst_beat_cnt #(
        .SIZEBURST(SIZEBURST)
    ) u_beat_cnt (
        .clk  (clk),
        .reset(reset),
        .clear(state_q == IDLE),
        .go   (beat_en),
        .len  (len_q),
        .count(beat_cnt),
        .last (beat_last)
    );

    assign timeout_hit = (TIMEOUT != 0) && (stall_q == SW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            len_q    <= '0;
            stall_q  <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            stall_q  <= stall_d;
            abort_q  <= abort_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        stall_d  = stall_q;
        abort_d  = abort_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_id_d = winner;
                    len_d    = len_win;
                    stall_d  = '0;
                    abort_d  = 1'b0;
                    // A zero-length burst never owns the datapath.
                    if (len_win == '0) begin
                        state_d = DONE;
                        gnt_d   = '0;
                    end else begin
                        state_d = BURST;
                        gnt_d   = NREQ'(1) << winner;
                    end
                end
            end
            BURST: begin
                if (beat_last) begin
                    state_d = DONE;
                    gnt_d   = '0;
                end else if (beat_en) begin
                    stall_d = '0;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    gnt_d   = '0;
                    abort_d = 1'b1;
                end else if (TIMEOUT != 0) begin
                    stall_d = stall_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                abort_d = 1'b0;
                ptr_d   = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        beat_en     = (state_q == BURST) && beat_valid && beat_ready;
        busy        = (state_q != IDLE);
        burst_done  = (state_q == DONE);
        burst_abort = (state_q == DONE) && abort_q;
        gnt         = gnt_q;
        gnt_id      = gnt_id_q;
        dbg_state   = state_q;
        dbg_beats   = beat_cnt;
    end

endmodule

// File: tb/tb_burst_scheduler.sv
// Bench for burst_scheduler: table-driven bursts, hand-written corner sequences and
// randomized traffic, all checked against a burst-level reference model.
module tb_burst_scheduler;

    localparam int NREQ = 4;
    localparam int SB   = 5;
    localparam int IDW  = 2;
    localparam int TMO  = 8;
    localparam int M_IDLE  = 0;
    localparam int M_BURST = 1;
    localparam int M_DONE  = 2;

    logic               clk        = 1'b0;
    logic               reset      = 1'b1;
    logic [NREQ-1:0]    req        = '0;
    logic [NREQ*SB-1:0] req_size   = '0;
    logic               beat_valid = 1'b0;
    logic               beat_ready = 1'b0;
    logic [NREQ-1:0]    gnt;
    logic [IDW-1:0]     gnt_id;
    logic               beat_en;
    logic               busy;
    logic               burst_done;
    logic               burst_abort;
    logic [1:0]         dbg_state;
    logic [SB-1:0]      dbg_beats;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NREQ-1:0]    req;
        logic [NREQ*SB-1:0] sizes;
        int                 gap;
        logic [NREQ-1:0]    exp_gnt;
        logic [IDW-1:0]     exp_id;
        int                 exp_beats;
        logic               exp_abort;
    } vec_t;

    vec_t           vecs[9];
    logic [IDW-1:0] exp_q[$];

    burst_scheduler #(
        .NREQ(NREQ), .SIZEBURST(SB), .IDW(IDW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_size(req_size),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .gnt(gnt), .gnt_id(gnt_id), .beat_en(beat_en), .busy(busy),
        .burst_done(burst_done), .burst_abort(burst_abort),
        .dbg_state(dbg_state), .dbg_beats(dbg_beats)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ*SB-1:0] pk(input int slot, input int len);
        logic [NREQ*SB-1:0] r;
        r = '0;
        r[slot*SB +: SB] = SB'(len);
        return r;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        int w;
        w = -1;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (r[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
        end
        return w;
    endfunction

    function automatic int size_of(input logic [NREQ*SB-1:0] s, input int idx);
        return int'(s[idx*SB +: SB]);
    endfunction

    // Reference model: burst-level bookkeeping of owner, beats moved and idle streak.
    int m_phase = M_IDLE;
    int m_ptr = 0, m_owner = 0, m_len = 0, m_beats = 0, m_stalls = 0;
    bit m_abort = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= M_IDLE; m_ptr <= 0; m_owner <= 0; m_len <= 0;
            m_beats <= 0; m_stalls <= 0; m_abort <= 1'b0;
        end else begin
            case (m_phase)
                M_IDLE: if (req != '0) begin
                    m_owner  <= pick(req, m_ptr);
                    m_len    <= size_of(req_size, pick(req, m_ptr));
                    m_beats  <= 0;
                    m_stalls <= 0;
                    m_abort  <= 1'b0;
                    m_phase  <= (size_of(req_size, pick(req, m_ptr)) == 0) ? M_DONE : M_BURST;
                end
                M_BURST: if (beat_valid && beat_ready) begin
                    m_beats  <= m_beats + 1;
                    m_stalls <= 0;
                    if (m_beats + 1 == m_len) m_phase <= M_DONE;
                end else begin
                    m_stalls <= m_stalls + 1;
                    if (m_stalls + 1 == TMO) begin
                        m_abort <= 1'b1;
                        m_phase <= M_DONE;
                    end
                end
                M_DONE: begin
                    m_ptr   <= (m_owner + 1) % NREQ;
                    m_phase <= M_IDLE;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        check("model_gnt", gnt, (m_phase == M_BURST) ? (32'd1 << m_owner) : 32'd0);
        if (m_phase == M_BURST) begin
            check("model_gnt_id", gnt_id, m_owner);
            check("model_beats", dbg_beats, m_beats);
        end
        check("model_busy", busy, m_phase != M_IDLE);
        check("model_done", burst_done, m_phase == M_DONE);
        check("model_abort", burst_abort, (m_phase == M_DONE) && m_abort);
        check("model_beat_en", beat_en, (m_phase == M_BURST) && beat_valid && beat_ready);
        check("model_state", dbg_state, m_phase);
    end

    task automatic wait_idle();
        for (int c = 0; c < 100 && busy; c++) begin
            @(posedge clk); #1;
        end
        check("idle_wait", busy, 0);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int beats, gap_left, cyc;
        bit seen_done, seen_abort;
        beats = 0; gap_left = v.gap; cyc = 0; seen_done = 0; seen_abort = 0;
        req = v.req; req_size = v.sizes; beat_valid = 1'b1; beat_ready = 1'b1;
        @(posedge clk); #1;
        req = '0;
        check($sformatf("vec%0d_gnt", n), gnt, v.exp_gnt);
        if (v.exp_gnt != '0) check($sformatf("vec%0d_id", n), gnt_id, v.exp_id);
        while (!seen_done && cyc < 100) begin
            beat_ready = !(beats == 1 && gap_left > 0);
            @(negedge clk);
            if (beat_en) beats++;
            else if (beats == 1 && gap_left > 0) gap_left--;
            if (burst_done) begin
                seen_done  = 1'b1;
                seen_abort = burst_abort;
                check($sformatf("vec%0d_gnt_at_done", n), gnt, 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("vec%0d_done_seen", n), seen_done, 1);
        check($sformatf("vec%0d_beats", n), beats, v.exp_beats);
        check($sformatf("vec%0d_abort", n), seen_abort, v.exp_abort);
        beat_ready = 1'b1;
    endtask

    initial begin
        int  beats, last_c, r;
        bit  prev_g, stall_mode;

        #1 reset = 1'b0;
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_busy", busy, 0);
        check("rst_done", burst_done, 0);
        check("rst_abort", burst_abort, 0);
        check("rst_beat_en", beat_en, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Pointer after each entry: 3,2,1,0,1,2,3,3,1 (zero-length burst still advances it).
        vecs[0] = '{4'b0100, pk(2, 3),             0,  4'b0100, 2'd2, 3,  1'b0};
        vecs[1] = '{4'b0010, pk(1, 0),             0,  4'b0000, 2'd1, 0,  1'b0};
        vecs[2] = '{4'b0011, pk(0, 2) | pk(1, 2),  0,  4'b0001, 2'd0, 2,  1'b0};
        vecs[3] = '{4'b1001, pk(0, 1) | pk(3, 1),  0,  4'b1000, 2'd3, 1,  1'b0};
        vecs[4] = '{4'b0001, pk(0, 4),             99, 4'b0001, 2'd0, 1,  1'b1};
        vecs[5] = '{4'b1111, pk(1, 31),            0,  4'b0010, 2'd1, 31, 1'b0};
        vecs[6] = '{4'b0100, pk(2, 2),             7,  4'b0100, 2'd2, 2,  1'b0};
        vecs[7] = '{4'b0100, pk(2, 2),             8,  4'b0100, 2'd2, 1,  1'b1};
        vecs[8] = '{4'b0001, pk(0, 3),             7,  4'b0001, 2'd0, 3,  1'b0};
        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // All four requesting, one-beat bursts: strict rotation, grants 3 cycles apart.
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        req = 4'b1111;
        req_size = pk(0, 1) | pk(1, 1) | pk(2, 1) | pk(3, 1);
        exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        last_c = -1;
        prev_g = 1'b0;
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (gnt != '0 && !prev_g) begin
                check("rr_order", gnt_id, exp_q.pop_front());
                if (last_c >= 0) check("rr_spacing", c - last_c, 3);
                last_c = c;
            end
            prev_g = (gnt != '0);
        end
        check("rr_all_granted", exp_q.size(), 0);
        req = '0;
        wait_idle();

        // Reset in the middle of a burst.
        req = 4'b0001; req_size = pk(0, 5);
        @(posedge clk); #1;
        req = '0;
        beats = 0;
        for (int c = 0; c < 10 && beats < 2; c++) begin
            @(negedge clk);
            if (beat_en) beats++;
        end
        check("mid_beats", beats, 2);
        @(posedge clk); #2 reset = 1'b0;
        #1;
        check("rst_mid_gnt", gnt, 0);
        check("rst_mid_busy", busy, 0);
        @(negedge clk);
        check("rst_mid_done", burst_done, 0);
        reset = 1'b1;
        req = 4'b1001; req_size = pk(0, 1) | pk(3, 1);
        @(posedge clk); #1;
        req = '0;
        check("ptr0_gnt", gnt, 4'b0001);
        wait_idle();
        req = 4'b1000;
        @(posedge clk); #1;
        req = '0;
        check("sole3_gnt", gnt, 4'b1000);
        wait_idle();

        stall_mode = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) stall_mode = ($urandom_range(0, 3) == 0);
            req = ($urandom_range(0, 2) == 0) ? '0 : NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                r = $urandom_range(0, 9);
                req_size[i*SB +: SB] = (r == 0) ? SB'(0) : (r == 1) ? {SB{1'b1}} : SB'($urandom_range(1, 6));
            end
            beat_valid = ($urandom_range(0, 7) != 0);
            beat_ready = stall_mode ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 799) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            @(posedge clk); #1;
        end
        req = '0;
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
